morse_char_assembler: RTL

Downstream consumer of the Morse timing FSM. Turns the FSM's level outputs dot, dash, lg (letter gap) and wg (word gap) into 8-bit ASCII characters. It accumulates elements into a symbol, decodes the symbol at each letter gap, and inserts a space at each word gap. Characters leave through a small FIFO with a valid/ready interface, feeding a UART or display stage.

---
 rtl/morse_char_assembler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/morse_char_assembler.sv
// rtl/morse_char_assembler.sv - Morse element/gap stream to ASCII characters through an output FIFO (option: MORSE_PUNCT_EN)
module morse_char_assembler #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SPACE_CHAR   = 8'h20,
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot,
    input  logic       dash,
    input  logic       lg,
    input  logic       wg,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] elem_count,
    output logic       sym_err,
    output logic       fifo_ovf
);

`ifdef MORSE_PUNCT_EN
    localparam logic [2:0] MAX_LEN = 3'd6;
`else
    localparam logic [2:0] MAX_LEN = 3'd5;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT_CHAR, EMIT_SPACE} state_t;

    state_t     state, state_d;
    logic       dot_q, dash_q, lg_q, wg_q;
    logic       rise_dot, rise_dash, rise_lg, rise_wg;
    logic [5:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       bad_q, bad_d;
    logic       err_d;
    logic       armed_q, armed_d;
    logic       pend_q, pend_d;
    logic       elem_new;
    logic       has_sym;
    logic       push;
    logic [7:0] push_data;
    logic [6:0] mask;
    logic [6:0] code;
    logic [7:0] decoded;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fcount;
    logic          full, pop, push_ok;

    assign rise_dot  = dot  & ~dot_q;
    assign rise_dash = dash & ~dash_q;
    assign rise_lg   = lg   & ~lg_q;
    assign rise_wg   = wg   & ~wg_q;

    // Marker bit above the element bits makes each length/pattern pair a unique code.
    always_comb begin
        mask = (7'd1 << cnt_q) - 7'd1;
        code = (7'd1 << cnt_q) | ({1'b0, shift_q} & mask);
        case (code)
            7'b101:     decoded = 8'h41;
            7'b11000:   decoded = 8'h42;
            7'b11010:   decoded = 8'h43;
            7'b1100:    decoded = 8'h44;
            7'b10:      decoded = 8'h45;
            7'b10010:   decoded = 8'h46;
            7'b1110:    decoded = 8'h47;
            7'b10000:   decoded = 8'h48;
            7'b100:     decoded = 8'h49;
            7'b10111:   decoded = 8'h4A;
            7'b1101:    decoded = 8'h4B;
            7'b10100:   decoded = 8'h4C;
            7'b111:     decoded = 8'h4D;
            7'b110:     decoded = 8'h4E;
            7'b1111:    decoded = 8'h4F;
            7'b10110:   decoded = 8'h50;
            7'b11101:   decoded = 8'h51;
            7'b1010:    decoded = 8'h52;
            7'b1000:    decoded = 8'h53;
            7'b11:      decoded = 8'h54;
            7'b1001:    decoded = 8'h55;
            7'b10001:   decoded = 8'h56;
            7'b1011:    decoded = 8'h57;
            7'b11001:   decoded = 8'h58;
            7'b11011:   decoded = 8'h59;
            7'b11100:   decoded = 8'h5A;
            7'b111111:  decoded = 8'h30;
            7'b101111:  decoded = 8'h31;
            7'b100111:  decoded = 8'h32;
            7'b100011:  decoded = 8'h33;
            7'b100001:  decoded = 8'h34;
            7'b100000:  decoded = 8'h35;
            7'b110000:  decoded = 8'h36;
            7'b111000:  decoded = 8'h37;
            7'b111100:  decoded = 8'h38;
            7'b111110:  decoded = 8'h39;
`ifdef MORSE_PUNCT_EN
            7'b1010101: decoded = 8'h2E;
            7'b1110011: decoded = 8'h2C;
            7'b1001100: decoded = 8'h3F;
`endif
            default:    decoded = UNKNOWN_CHAR;
        endcase
        if (bad_q) decoded = UNKNOWN_CHAR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            lg_q    <= 1'b0;
            wg_q    <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            sym_err <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state   <= state_d;
            dot_q   <= dot;
            dash_q  <= dash;
            lg_q    <= lg;
            wg_q    <= wg;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            sym_err <= err_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        bad_d     = bad_q;
        err_d     = sym_err;
        armed_d   = armed_q;
        pend_d    = pend_q;
        elem_new  = 1'b0;
        has_sym   = 1'b0;
        push      = 1'b0;
        push_data = decoded;
        case (state)
            IDLE, COLLECT: begin
                if (rise_dot && rise_dash) begin
                    err_d = 1'b1;
                end else if (rise_dot || rise_dash) begin
                    elem_new = 1'b1;
                    if (cnt_q == MAX_LEN) begin
                        err_d = 1'b1;
                        bad_d = 1'b1;
                    end else begin
                        shift_d = {shift_q[4:0], rise_dash};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                // A coincident element joins the symbol before any gap closes it.
                has_sym = (state == COLLECT) || elem_new;
                if (rise_wg) begin
                    if (has_sym) begin
                        state_d = EMIT_CHAR;
                        pend_d  = 1'b1;
                    end else if (armed_q) begin
                        state_d = EMIT_SPACE;
                    end
                end else if (rise_lg) begin
                    if (has_sym) state_d = EMIT_CHAR;
                end else if (elem_new) begin
                    state_d = COLLECT;
                end
            end
            EMIT_CHAR: begin
                push    = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
                bad_d   = 1'b0;
                armed_d = 1'b1;
                state_d = pend_q ? EMIT_SPACE : IDLE;
            end
            EMIT_SPACE: begin
                push      = 1'b1;
                push_data = SPACE_CHAR;
                armed_d   = 1'b0;
                pend_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign elem_count = cnt_q;

    assign out_valid = (fcount != '0);
    assign full      = (fcount == (AW+1)'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcount   <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok) fifo_ovf <= 1'b1;
            case ({push_ok, pop})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: fcount <= fcount;
            endcase
        end
    end

endmodule
